// File: rtl/wisc_pipe_pkg.sv
// Shared types and constants for the WISC-S15 pipeline hazard/scoreboard logic.
// Register numbers are stored zero-extended to SB_RD_W so any REG_AW up to that width fits.
package wisc_pipe_pkg;

    localparam int REG_AW_DEF  = 4;
    localparam int SB_RD_W     = 8;
    localparam int FWD_REGFILE = 0;

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    typedef struct packed {
        logic               v;
        logic               wr;
        logic [SB_RD_W-1:0] rd;
        logic               ld;
    } sb_entry_t;

    // R0 is hardwired zero, so a write to it never produces a dependency
    function automatic logic sb_match(input sb_entry_t e, input logic [SB_RD_W-1:0] r);
        return e.v & e.wr & (e.rd == r) & (r != {SB_RD_W{1'b0}});
    endfunction

endpackage

// File: rtl/wisc_hazard_ctrl_if.sv
// ID-stage request / pipeline-control bundle between the pipeline top and wisc_hazard_ctrl.
// Perf counter signals exist only when WISC_HAZ_PERF_EN is defined.
interface wisc_hazard_ctrl_if #(
    parameter int SB_DEPTH = 3,
    parameter int REG_AW   = 4
);
    localparam int FSW = $clog2(SB_DEPTH);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr;
    logic [REG_AW-1:0] id_rd;
    logic              id_load;
    logic              ex_br_taken;
    logic              mem_wait;

    logic                pc_hold;
    logic                ifid_hold;
    logic                ifid_flush;
    logic                idex_bubble;
    logic [FSW-1:0]      fwd_a_sel;
    logic [FSW-1:0]      fwd_b_sel;
    logic [SB_DEPTH-1:0] stage_valid;
`ifdef WISC_HAZ_PERF_EN
    logic [15:0]         stall_cnt;
    logic [15:0]         flush_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_load,
        output ex_br_taken, mem_wait,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel, stage_valid
`ifdef WISC_HAZ_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_load,
        input  ex_br_taken, mem_wait,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel, stage_valid
`ifdef WISC_HAZ_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/wisc_fwd_pick.sv
// Priority match of one source register against the scoreboard; the youngest producer
// (lowest stage index) wins. Select k means "take the value now in scoreboard stage k".
module wisc_fwd_pick
    import wisc_pipe_pkg::*;
#(
    parameter int SB_DEPTH = 3,
    parameter int FSW      = $clog2(SB_DEPTH)
) (
    input  sb_entry_t [SB_DEPTH-1:0] entries,
    input  logic [SB_RD_W-1:0]       src,
    input  logic                     use_src,
    output logic [FSW-1:0]           sel
);

    // The oldest stage and the load flags are never forwarding candidates
    logic pick_unused_s;
    assign pick_unused_s = ^entries;

    // Scan oldest to youngest so the last hit (smallest k) is what remains
    always_comb begin
        sel = FSW'(FWD_REGFILE);
        for (int k = SB_DEPTH - 1; k >= SB_MEM; k--) begin
            if (use_src && sb_match(entries[k-1], src)) begin
                sel = FSW'(k);
            end else begin
                sel = sel;
            end
        end
    end

endmodule

// File: rtl/wisc_hazard_ctrl.sv
// Hazard and pipeline-control block for the WISC-S15 pipeline: scoreboard, load-use stall,
// branch flush, memory-wait freeze and registered EX forwarding. Optional: WISC_HAZ_PERF_EN.
module wisc_hazard_ctrl
    import wisc_pipe_pkg::*;
#(
    parameter int SB_DEPTH   = 3,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LOAD_READY = SB_WB
) (
    input logic               clk,
    input logic               rst,
    wisc_hazard_ctrl_if.slave hz
);

    localparam int FSW = $clog2(SB_DEPTH);

    sb_entry_t [SB_DEPTH-1:0] entry_r;
    logic [FSW-1:0]           fwd_a_sel_r;
    logic [FSW-1:0]           fwd_b_sel_r;

    logic [REG_AW-1:0]   rs_s, rt_s, rd_s;
    logic [SB_RD_W-1:0]  rs_ext_s, rt_ext_s, rd_ext_s;
    logic                frozen_s, lu_s, fl_s, bubble_s;
    logic                pc_hold_s, ifid_flush_s;
    logic [FSW-1:0]      pick_a_s, pick_b_s;
    sb_entry_t           new_entry_s;
    logic [SB_DEPTH-1:0] stage_valid_s;
    logic                sb_unused_s;

    assign rs_s     = hz.id_rs;
    assign rt_s     = hz.id_rt;
    assign rd_s     = hz.id_rd;
    assign rs_ext_s = SB_RD_W'(rs_s);
    assign rt_ext_s = SB_RD_W'(rt_s);
    assign rd_ext_s = SB_RD_W'(rd_s);

    // Not every stage's rd/ld is consumed for every LOAD_READY / depth choice
    assign sb_unused_s = ^entry_r;

    // Control decode; everything is held quiet while reset is asserted
    always_comb begin
        frozen_s = hz.mem_wait & ~rst;
        fl_s     = hz.ex_br_taken & entry_r[SB_EX].v & ~frozen_s & ~rst;
        lu_s     = 1'b0;
        for (int i = 0; i < LOAD_READY - 1; i++) begin
            if (entry_r[i].ld &&
                ((sb_match(entry_r[i], rs_ext_s) && hz.id_use_rs) ||
                 (sb_match(entry_r[i], rt_ext_s) && hz.id_use_rt))) begin
                lu_s = 1'b1;
            end else begin
                lu_s = lu_s;
            end
        end
        lu_s = lu_s & hz.id_valid & ~rst;
    end

    // Pipeline-control outputs; a flush squashes the stalled ID instruction
    always_comb begin
        pc_hold_s    = 1'b0;
        ifid_flush_s = 1'b0;
        bubble_s     = 1'b0;
        if (frozen_s) begin
            pc_hold_s = 1'b1;
        end else begin
            ifid_flush_s = fl_s;
            bubble_s     = fl_s | lu_s;
            pc_hold_s    = lu_s & ~fl_s;
        end
    end

    // Entry presented by ID for the next advance
    always_comb begin
        new_entry_s = {hz.id_valid, hz.id_wr, rd_ext_s, hz.id_load};
    end

    wisc_fwd_pick #(.SB_DEPTH(SB_DEPTH), .FSW(FSW)) u_pick_a (
        .entries (entry_r),
        .src     (rs_ext_s),
        .use_src (hz.id_use_rs),
        .sel     (pick_a_s)
    );

    wisc_fwd_pick #(.SB_DEPTH(SB_DEPTH), .FSW(FSW)) u_pick_b (
        .entries (entry_r),
        .src     (rt_ext_s),
        .use_src (hz.id_use_rt),
        .sel     (pick_b_s)
    );

    // Scoreboard shift and forwarding-select registers; both hold while frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                entry_r[i] <= {$bits(sb_entry_t){1'b0}};
            end
            fwd_a_sel_r <= {FSW{1'b0}};
            fwd_b_sel_r <= {FSW{1'b0}};
        end else if (!frozen_s) begin
            for (int i = SB_DEPTH - 1; i >= 1; i--) begin
                entry_r[i] <= entry_r[i-1];
            end
            entry_r[SB_EX] <= bubble_s ? {$bits(sb_entry_t){1'b0}} : new_entry_s;
            fwd_a_sel_r    <= bubble_s ? {FSW{1'b0}} : pick_a_s;
            fwd_b_sel_r    <= bubble_s ? {FSW{1'b0}} : pick_b_s;
        end else begin
            entry_r     <= entry_r;
            fwd_a_sel_r <= fwd_a_sel_r;
            fwd_b_sel_r <= fwd_b_sel_r;
        end
    end

    // Per-stage valid view of the scoreboard
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            stage_valid_s[i] = entry_r[i].v;
        end
    end

    assign hz.pc_hold     = pc_hold_s;
    assign hz.ifid_hold   = pc_hold_s;
    assign hz.ifid_flush  = ifid_flush_s;
    assign hz.idex_bubble = bubble_s;
    assign hz.fwd_a_sel   = fwd_a_sel_r;
    assign hz.fwd_b_sel   = fwd_b_sel_r;
    assign hz.stage_valid = stage_valid_s;

`ifdef WISC_HAZ_PERF_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating stall / flush event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (lu_s && !fl_s && !frozen_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (fl_s && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_r;
    assign hz.flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_wisc_hazard_ctrl.sv
// Self-checking bench for wisc_hazard_ctrl: directed scenarios plus random traffic,
// all compared each cycle against a behavioural pipeline model kept in the bench.
module tb_wisc_hazard_ctrl;

    localparam int D  = 3;
    localparam int AW = 4;
    localparam int LR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wisc_hazard_ctrl_if #(.SB_DEPTH(D), .REG_AW(AW)) hz ();

    wisc_hazard_ctrl #(.SB_DEPTH(D), .REG_AW(AW), .LOAD_READY(LR)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        bit v;
        bit wr;
        int rd;
        bit ld;
    } instr_t;

    instr_t pipe[D];
    int     efa, efb;
    int     e_stall, e_flush;
    bit     known = 1'b0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input int i, input int r);
        return pipe[i].v && pipe[i].wr && (pipe[i].rd == r) && (r != 0);
    endfunction

    function automatic bit m_lu();
        bit hit = 1'b0;
        for (int i = 0; i < LR - 1; i++) begin
            if (pipe[i].ld && ((writes(i, int'(hz.id_rs)) && hz.id_use_rs) ||
                               (writes(i, int'(hz.id_rt)) && hz.id_use_rt))) hit = 1'b1;
        end
        return hit && hz.id_valid;
    endfunction

    function automatic int m_src(input int r, input bit u);
        if (!u) return 0;
        for (int k = 1; k < D; k++) begin
            if (writes(k - 1, r)) return k;
        end
        return 0;
    endfunction

    // Compare every output against the model, then advance the model on the clock edge
    task automatic step();
        bit fl, lu, bub, hold, flush;
        int sv;
        #1;
        fl = 1'b0; lu = 1'b0; bub = 1'b0; hold = 1'b0; flush = 1'b0;
        if (!rst) begin
            if (hz.mem_wait) begin
                hold = 1'b1;
            end else begin
                fl    = hz.ex_br_taken && pipe[0].v;
                lu    = m_lu();
                flush = fl;
                bub   = fl || lu;
                hold  = lu && !fl;
            end
        end
        chk("pc_hold", int'(hz.pc_hold), int'(hold));
        chk("ifid_hold", int'(hz.ifid_hold), int'(hold));
        chk("ifid_flush", int'(hz.ifid_flush), int'(flush));
        chk("idex_bubble", int'(hz.idex_bubble), int'(bub));
        if (known) begin
            sv = 0;
            for (int i = 0; i < D; i++) if (pipe[i].v) sv += (1 << i);
            chk("stage_valid", int'(hz.stage_valid), sv);
            chk("fwd_a_sel", int'(hz.fwd_a_sel), efa);
            chk("fwd_b_sel", int'(hz.fwd_b_sel), efb);
`ifdef WISC_HAZ_PERF_EN
            chk("stall_cnt", int'(hz.stall_cnt), e_stall);
            chk("flush_cnt", int'(hz.flush_cnt), e_flush);
`endif
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < D; i++) pipe[i] = '{0, 0, 0, 0};
            efa = 0; efb = 0; e_stall = 0; e_flush = 0;
            known = 1'b1;
        end else if (!hz.mem_wait) begin
            efa = bub ? 0 : m_src(int'(hz.id_rs), hz.id_use_rs);
            efb = bub ? 0 : m_src(int'(hz.id_rt), hz.id_use_rt);
            for (int i = D - 1; i >= 1; i--) pipe[i] = pipe[i-1];
            if (bub) pipe[0] = '{0, 0, 0, 0};
            else     pipe[0] = '{hz.id_valid, hz.id_wr, int'(hz.id_rd), hz.id_load};
            if (hold && e_stall < 65535) e_stall++;
            if (fl && e_flush < 65535) e_flush++;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit wr, input int rd, input bit ld);
        hz.id_valid  = v;
        hz.id_rs     = AW'(rs);
        hz.id_rt     = AW'(rt);
        hz.id_use_rs = urs;
        hz.id_use_rt = urt;
        hz.id_wr     = wr;
        hz.id_rd     = AW'(rd);
        hz.id_load   = ld;
    endtask

    task automatic set_ctl(input bit br, input bit mw);
        hz.ex_br_taken = br;
        hz.mem_wait    = mw;
    endtask

    task automatic rand_id();
        set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7), $urandom_range(0, 2) == 0);
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) pipe[i] = '{0, 0, 0, 0};
        efa = 0; efb = 0; e_stall = 0; e_flush = 0;
        rst = 1'b1;
        rand_id();
        set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);

        // Reset with random inputs
        for (int c = 0; c < 2; c++) begin
            rand_id();
            set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        #1 chk("reset stage_valid", int'(hz.stage_valid), 0);
        chk("reset pc_hold", int'(hz.pc_hold), 0);
        rst = 1'b0;
        idle(); set_ctl(1'b0, 1'b0);
        step();

        // Load-use: LW R3 in EX, ID reads R3
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1); step();
        set_id(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 4, 1'b0);
        #1 chk("lu bubble", int'(hz.idex_bubble), 1);
        chk("lu pc_hold", int'(hz.pc_hold), 1);
        chk("lu ifid_hold", int'(hz.ifid_hold), 1);
        step();
        #1 chk("lu released", int'(hz.pc_hold), 0);
        chk("lu no 2nd bubble", int'(hz.idex_bubble), 0);
        step();
        idle();
        #1 chk("lu fwd_a=2", int'(hz.fwd_a_sel), 2);
        step();

        // ALU chain and R0
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0); step();
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        #1 chk("alu no stall", int'(hz.pc_hold), 0);
        step();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        #1 chk("alu fwd_a=1", int'(hz.fwd_a_sel), 1);
        chk("alu fwd_b=1", int'(hz.fwd_b_sel), 1);
        step();
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 8, 1'b0); step();
        idle();
        #1 chk("r0 fwd_a=0", int'(hz.fwd_a_sel), 0);
        chk("r0 fwd_b=0", int'(hz.fwd_b_sel), 0);
        step();

        // Taken branch together with a load-use hazard
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b1); step();
        set_id(1'b1, 7, 0, 1'b1, 1'b0, 1'b1, 1, 1'b0); set_ctl(1'b1, 1'b0);
        #1 chk("br flush", int'(hz.ifid_flush), 1);
        chk("br bubble", int'(hz.idex_bubble), 1);
        chk("br pc_hold", int'(hz.pc_hold), 0);
        step();
        idle(); set_ctl(1'b0, 1'b0);
        #1 chk("br ex squashed", int'(hz.stage_valid[0]), 0);
        step();

        // mem_wait held for 3 cycles with a branch asserted
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0); step();
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 9, 1'b0); step();
        for (int c = 0; c < 3; c++) begin
            rand_id(); set_ctl(1'b1, 1'b1);
            #1 chk("mw pc_hold", int'(hz.pc_hold), 1);
            chk("mw no flush", int'(hz.ifid_flush), 0);
            chk("mw fwd_a", int'(hz.fwd_a_sel), 1);
            chk("mw stage_valid", int'(hz.stage_valid), 3);
            step();
        end
        set_ctl(1'b0, 1'b0);

        // Youngest producer wins
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0); step();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0); step();
        set_id(1'b1, 2, 2, 1'b1, 1'b1, 1'b1, 10, 1'b0); step();
        idle();
        #1 chk("young fwd_a=1", int'(hz.fwd_a_sel), 1);
        chk("young fwd_b=1", int'(hz.fwd_b_sel), 1);
`ifdef WISC_HAZ_PERF_EN
        chk("perf stall_cnt", int'(hz.stall_cnt), 1);
        chk("perf flush_cnt", int'(hz.flush_cnt), 1);
`endif
        step();

        // Random traffic, occasional mid-stream reset
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            rand_id();
            set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wisc_hazard_ctrl.md
Name: wisc_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control block for the WISC-S15 5-stage pipeline.
- Drives the unresolved hazard, PC_src and flush hooks on the IF_Unit, IFID_reg and IDEX_reg instances at the pipeline top level.
- Keeps a per-stage scoreboard of in-flight register writes behind ID.
- From that scoreboard it produces load-use stalls, branch flushes, global memory-wait freezes and registered EX forwarding selects. Depth and load-data readiness are generalised.

Parameters:
- SB_DEPTH, 3: number of tracked stages after ID; index 0 = EX, 1 = MEM, 2 = WB.
- REG_AW, 4: register address width.
- LOAD_READY, 2: scoreboard index at which load data is forwardable (2 = from MEM/WB). Legal range 1..SB_DEPTH-1.
- FSW, $clog2(SB_DEPTH), derived localparam: forward-select width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source A
- id_rt  in  REG_AW  source B
- id_use_rs  in  1  ID reads rs
- id_use_rt  in  1  ID reads rt
- id_wr  in  1  ID writes a register
- id_rd  in  REG_AW  ID destination
- id_load  in  1  ID is LW
- ex_br_taken  in  1  EX resolved a taken branch/call/ret
- mem_wait  in  1  memory not ready; freeze the pipe
- pc_hold  out  1  IF must not advance PC
- ifid_hold  out  1  IFID_reg keeps its contents
- ifid_flush  out  1  IFID_reg loads a NOP
- idex_bubble  out  1  IDEX_reg loads a NOP
- fwd_a_sel  out  FSW  EX operand A source: 0 = regfile, k = scoreboard stage k
- fwd_b_sel  out  FSW  EX operand B source, same encoding
- stage_valid  out  SB_DEPTH  valid bit per tracked stage

Behaviour:
- Scoreboard: entry[i] = {v, wr, rd, ld}, i = 0..SB_DEPTH-1.
- Reset: all entries zero. All outputs 0 on the cycle after rst is sampled high; rst mid-operation discards every in-flight entry.
- Frozen = mem_wait.
  - Frozen: no entry shifts. pc_hold = ifid_hold = 1; ifid_flush = idex_bubble = 0. fwd selects and stage_valid hold their values. ex_br_taken is ignored.
- Match(i, r) = entry[i].v & entry[i].wr & (entry[i].rd == r) & (r != 0). R0 is hardwired zero and never matches.
- Load-use stall:
  - lu = id_valid & some i < LOAD_READY-1 with entry[i].ld & (Match(i,rs) & id_use_rs | Match(i,rt) & id_use_rt).
  - With the default LOAD_READY = 2, this is a load in EX only: 1-cycle stall.
- Flush: fl = ex_br_taken & entry[0].v & ~frozen.
- Combinational outputs when not frozen:
  - ifid_flush = fl.
  - idex_bubble = fl | lu.
  - pc_hold = ifid_hold = lu & ~fl.
  - Flush wins over load-use: the stalled ID instruction is squashed.
- Advance, every non-frozen cycle:
  - entry[i] <= entry[i-1] for i >= 1.
  - entry[0] <= idex_bubble ? 0 : {id_valid, id_wr, id_rd, id_load}.
- Forwarding, registered on advance, so aligned with the instruction then in EX:
  - fwd_a_sel <= smallest k in 1..SB_DEPTH-1 with Match(k-1, rs) & id_use_rs, else 0. Smallest k means the youngest producer wins.
  - fwd_b_sel: same rule using rt / id_use_rt.
  - Both are forced to 0 when a bubble is inserted.
- Write-back-stage producers need no forward: the regfile writes through in the same cycle.
- stage_valid[i] = entry[i].v, registered.
- Simultaneous mem_wait and ex_br_taken: freeze wins. The branch is re-presented by EX when the pipe unfreezes.

Optional Feature:
- Macro WISC_HAZ_PERF_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0], both saturating at 16'hFFFF and cleared by rst.
  - stall_cnt increments each cycle lu & ~fl & ~frozen.
  - flush_cnt increments each cycle fl.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package wisc_pipe_pkg:
  - sb_entry_t struct {v, wr, rd, ld}.
  - REG_AW default.
  - FWD_REGFILE = 0 constant.
  - Stage index constants SB_EX, SB_MEM, SB_WB.
- Sub-module wisc_fwd_pick: combinational priority match of one source register against the scoreboard, returning the select. Instantiated twice, for A and B.

Test Plan:
- Reset: drive rst for 2 cycles with random inputs. Expect all outputs 0 and stage_valid = 3'b000.
- Load-use: LW R3 in EX, ID reads rs = R3. Expect idex_bubble = pc_hold = ifid_hold = 1 for exactly 1 cycle. The next cycle's advance gives fwd_a_sel = 2.
- ALU chain: ADD R5 then SUB using rs = R5, rt = R5. Expect fwd_a_sel = fwd_b_sel = 1 and no stall. Using R0 instead gives sel 0.
- Taken branch in EX together with a load-use hazard in ID: expect ifid_flush = idex_bubble = 1 and pc_hold = 0. The next cycle entry[0].v = 0.
- mem_wait held for 3 cycles mid-stream: stage_valid and the fwd selects stay unchanged and pc_hold = 1. ex_br_taken asserted during the wait causes no flush.
- Youngest wins: R2 is written in both MEM and EX, ID reads R2. Expect sel = 1. With WISC_HAZ_PERF_EN defined, stall_cnt and flush_cnt match the scenario counts.
